hap_fetch: RTL and testbench

- Instruction fetch unit for the Harvard Architecture Processor.
- Owns the program counter and reads 16-bit instruction words from the synchronous instruction memory.
- Buffers fetched words and presents each instruction with its NPC to decode and branch resolution.
- Accepts the resolved branch PC back as a redirect, closing the loop that the branch block opens.

---
 rtl/hap_fetch.sv | 72 +++++++
 tb/tb_hap_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hap_fetch.sv
// hap_fetch: PC, synchronous imem issue and 2-entry instruction buffer; define FETCH_HALT_EN to halt on a fetched 16'h0000
module hap_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] npc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              halted
);
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic inflight, pop, push, zero_push, wsel;
  logic [1:0] count;
  logic [2:0] occ;
  logic [DATA_W-1:0] q_instr [2];
  logic [ADDR_W-1:0] q_npc [2];
  assign imem_addr = pc;
  assign instr = q_instr[0];
  assign npc = q_npc[0];
  assign instr_valid = count != 2'd0;
  always_comb begin
    pop = instr_valid & instr_ready;
    push = inflight & ~br_taken;
    wsel = count > {1'b0, pop};
    occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    imem_en = (state == RUN) & ~br_taken & (occ < 3'd2);
`ifdef FETCH_HALT_EN
    zero_push = push & (imem_rdata == '0);
    halted = state == HALTED;
`else
    zero_push = 1'b0;
    halted = 1'b0;
`endif
    state_nx = (br_taken || state == BOOT) ? RUN : zero_push ? HALTED : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      count <= 2'd0;
      q_instr <= '{'0, '0};
      q_npc <= '{'0, '0};
    end else begin
      inflight <= imem_en;
      pc <= br_taken ? br_target : imem_en ? pc + ADDR_W'(1) : pc;
      count <= br_taken ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        q_instr[0] <= q_instr[1];
        q_npc[0] <= q_npc[1];
      end
      if (push) begin
        q_instr[wsel] <= imem_rdata;
        q_npc[wsel] <= pc;
      end
    end
  end
endmodule

// File: tb/tb_hap_fetch.sv
// tb_hap_fetch: randomized fetch-unit bench against a queue-based reference model
module tb_hap_fetch;
  logic clk, rst, imem_en, instr_valid, instr_ready, br_taken, halted;
  logic [7:0] imem_addr, npc, br_target;
  logic [15:0] imem_rdata, instr;
  logic [15:0] rom [256];
  int checks = 0, errors = 0;
  logic [15:0] mi[$];
  logic [7:0] mn[$];
  bit mfl;
  logic [7:0] mfa, mpc;
  int mst;
  logic [15:0] got_i[$];
  logic [7:0] got_n[$];
  logic [7:0] iss[$];
  int cyc, first_valid;
  int gi, ii;

  hap_fetch dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .npc(npc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .br_taken(br_taken), .br_target(br_target), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_en();
    int occ;
    occ = mi.size() + int'(mfl) - int'(mi.size() != 0 && instr_ready);
    return mst == 1 && !br_taken && occ < 2;
  endfunction

  // reference: buffered words as a queue, at most one word in flight
  always @(posedge clk or posedge rst) begin
    bit pop, en;
    if (rst) begin
      mi.delete(); mn.delete();
      mfl = 0; mfa = 8'h00; mpc = 8'h00; mst = 0;
    end else begin
      pop = mi.size() != 0 && instr_ready;
      en = model_en();
      if (br_taken) begin
        mi.delete(); mn.delete();
        mfl = 0; mpc = br_target; mst = 1;
      end else begin
        if (pop) begin
          void'(mi.pop_front());
          void'(mn.pop_front());
        end
        if (mfl) begin
          mi.push_back(rom[mfa]);
          mn.push_back(mfa + 8'd1);
`ifdef FETCH_HALT_EN
          if (rom[mfa] == 16'h0000) mst = 2;
`endif
        end
        if (mst == 0) mst = 1;
        mfl = en;
        if (en) begin
          mfa = mpc;
          mpc = mpc + 8'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    ev = model_en();
    chk("imem_en", imem_en, ev);
    if (ev) chk("imem_addr", imem_addr, mpc);
    chk("instr_valid", instr_valid, mi.size() != 0);
    if (mi.size() != 0) begin
      chk("instr", instr, mi[0]);
      chk("npc", npc, mn[0]);
    end
    chk("halted", halted, mst == 2);
    if (rst) begin
      cyc = 0;
      first_valid = -1;
    end else begin
      if (instr_valid && first_valid < 0) first_valid = cyc;
      cyc++;
      if (imem_en) iss.push_back(imem_addr);
      if (instr_valid && instr_ready) begin
        got_i.push_back(instr);
        got_n.push_back(npc);
      end
    end
  end

  task automatic drive(input bit rdy, input bit br, input logic [7:0] tgt, input int n);
    instr_ready = rdy;
    br_taken = br;
    br_target = tgt;
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hA000 + 16'(i);
    rst = 1'b1; instr_ready = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    repeat (3) @(posedge clk);
    #3;
    chk("rst imem_en", imem_en, 0);
    chk("rst imem_addr", imem_addr, 8'h00);
    chk("rst instr", instr, 16'h0000);
    chk("rst npc", npc, 8'h00);
    chk("rst instr_valid", instr_valid, 0);
    chk("rst halted", halted, 0);
    rst = 1'b0;
    drive(1, 0, 8'h00, 12);
    chk("first_valid cycle", first_valid, 3);
    for (int k = 0; k < 3; k++) begin
      chk("startup issue addr", iss[k], 8'(k));
      chk("startup instr", got_i[k], 16'hA000 + 16'(k));
      chk("startup npc", got_n[k], 8'(k + 1));
    end
    drive(0, 0, 8'h00, 6);
    @(negedge clk);
    #1;
    chk("stall valid", instr_valid, 1);
    chk("stall imem_en", imem_en, 0);
    @(posedge clk);
    #3;
    drive(1, 0, 8'h00, 4);
    for (int k = 0; k < got_n.size(); k++) begin
      chk("stream npc", got_n[k], 8'(k + 1));
      chk("stream instr", got_i[k], 16'hA000 + 16'(k));
    end
    gi = got_n.size();
    drive(0, 1, 8'h40, 1);
    chk("post-br valid", instr_valid, 0);
    drive(1, 0, 8'h00, 6);
    chk("redirect instr", got_i[gi], rom[8'h40]);
    chk("redirect npc", got_n[gi], 8'h41);
    gi = got_n.size();
    ii = iss.size();
    drive(0, 1, 8'hFE, 1);
    drive(1, 0, 8'h00, 8);
    chk("wrap issue 0", iss[ii], 8'hFE);
    chk("wrap issue 1", iss[ii + 1], 8'hFF);
    chk("wrap issue 2", iss[ii + 2], 8'h00);
    chk("wrap npc 0", got_n[gi], 8'hFF);
    chk("wrap npc 1", got_n[gi + 1], 8'h00);
    chk("wrap npc 2", got_n[gi + 2], 8'h01);
    chk("wrap instr 1", got_i[gi + 1], 16'hA0FF);
    for (int k = 0; k < 400; k++)
      drive($urandom_range(3) != 0, $urandom_range(15) == 0, 8'($urandom), 1);
    drive(1, 0, 8'h00, 4);
    rst = 1'b1;
    #1;
    chk("midrst imem_en", imem_en, 0);
    chk("midrst valid", instr_valid, 0);
    chk("midrst instr", instr, 16'h0000);
    chk("midrst npc", npc, 8'h00);
    chk("midrst imem_addr", imem_addr, 8'h00);
    @(posedge clk);
    #3;
    ii = iss.size();
    gi = got_n.size();
    rst = 1'b0;
    drive(1, 0, 8'h00, 8);
    chk("refetch addr", iss[ii], 8'h00);
    chk("refetch instr", got_i[gi], 16'hA000);
    chk("refetch npc", got_n[gi], 8'h01);
    rst = 1'b1;
    rom[5] = 16'h0000;
    @(posedge clk);
    #3;
    gi = got_n.size();
    rst = 1'b0;
    drive(1, 0, 8'h00, 16);
    chk("zero word", got_i[gi + 5], 16'h0000);
`ifdef FETCH_HALT_EN
    chk("halted set", halted, 1);
    chk("halted no issue", imem_en, 0);
    chk("halt delivered count", got_n.size() - gi, 7);
    gi = got_n.size();
    drive(1, 1, 8'h10, 1);
    drive(1, 0, 8'h00, 6);
    chk("halted cleared", halted, 0);
    chk("resume instr", got_i[gi], 16'hA010);
    chk("resume npc", got_n[gi], 8'h11);
`else
    chk("no-halt halted", halted, 0);
    chk("no-halt instr 6", got_i[gi + 6], 16'hA006);
    chk("no-halt npc 6", got_n[gi + 6], 8'h07);
`endif
    for (int k = 0; k < 300; k++)
      drive($urandom_range(3) != 0, $urandom_range(15) == 0, 8'($urandom_range(15)), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
